// File: rtl/hjdebug_seq_if.sv
// ============================================================================
// Module : hjdebug_seq_if
// Brief  : Command, trigger-stream, readout-stream and core register bus of
//          the hjdebug sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hjdebug_seq_if;
    logic        go;
    logic        abort;
    logic [15:0] tpos;
    logic        trans;
    logic        trig_valid;
    logic [31:0] trig_data;
    logic        trig_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic        regreq;
    logic        regwr;
    logic [11:0] regaddr;
    logic [31:0] regwdata;
    logic        regack;
    logic        regerr;
    logic [31:0] regrdata;

    modport master (
        input  go, abort, tpos, trans, trig_valid, trig_data, out_ready,
               regack, regerr, regrdata,
        output trig_ready, out_valid, out_data, out_last, busy, done, err,
               regreq, regwr, regaddr, regwdata
    );

    modport slave (
        output go, abort, tpos, trans, trig_valid, trig_data, out_ready,
               regack, regerr, regrdata,
        input  trig_ready, out_valid, out_data, out_last, busy, done, err,
               regreq, regwr, regaddr, regwdata
    );
endinterface

`default_nettype wire

// File: rtl/hjdebug_seq.sv
// ============================================================================
// Module : hjdebug_seq
// Brief  : Bus master that loads, arms, polls and drains one hjdebug core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hjdebug_seq #(
    parameter int N       = 1,
    parameter int SIZ     = 1024,
    parameter int NTRIG   = 1,
    parameter int POLLGAP = 256,
    parameter int TIMEOUT = 65535
) (
    input  wire logic     clk,
    input  wire logic     rst,
    hjdebug_seq_if.master bus
);
    localparam int c_WPS   = (N + 31) / 32;
    localparam int c_TOTAL = SIZ * c_WPS;
    localparam int c_CW    = $clog2(c_TOTAL) + 1;
    localparam int c_TW    = $clog2(NTRIG) + 1;
    localparam int c_GW    = $clog2(POLLGAP + 1) + 1;
    localparam int c_MW    = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARM   = 3'd2,
        S_POLL  = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6,
        S_ABORT = 3'd7
    } state_t;

    state_t            r_state, w_nxt;
    logic              r_pend, r_req, r_wr, r_trans, r_abt, r_ovalid;
    logic [c_MW-1:0]   r_tmo;
    logic [c_GW-1:0]   r_gap;
    logic [c_CW-1:0]   r_cnt;
    logic [c_TW-1:0]   r_tcnt;
    logic [15:0]       r_tpos;
    logic [11:0]       r_addr;
    logic [31:0]       r_wdata, r_odata;

    logic              w_issue, w_iwr, w_start, w_lut_ok, w_retry, w_rd_ack, w_hs, w_trig_rdy;
    logic [11:0]       w_iaddr;
    logic [31:0]       w_iwdata;

    wire logic        w_busy_st = (r_state == S_LOAD) || (r_state == S_ARM) ||
                                   (r_state == S_POLL) || (r_state == S_READ);
    wire logic        w_tmo     = (r_tmo == c_MW'(TIMEOUT - 1));
    wire logic        w_fin     = r_pend && (bus.regack || w_tmo);
    wire logic        w_bad     = !bus.regack || bus.regerr;
    wire logic        w_abt     = r_abt || bus.abort;
    wire logic        w_last    = (r_cnt == c_CW'(c_TOTAL - 1));
    wire logic [31:0] w_ctrl_start = {r_tpos, 7'd0, r_trans, 6'd0, 2'b01};
    wire logic [31:0] w_ctrl_abort = {r_tpos, 7'd0, r_trans, 6'd0, 2'b10};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt      = r_state;
        w_issue    = 1'b0;
        w_iwr      = 1'b0;
        w_iaddr    = 12'd0;
        w_iwdata   = 32'd0;
        w_start    = 1'b0;
        w_lut_ok   = 1'b0;
        w_retry    = 1'b0;
        w_rd_ack   = 1'b0;
        w_hs       = 1'b0;
        w_trig_rdy = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.go && !bus.abort) begin
                    w_nxt   = S_LOAD;
                    w_start = 1'b1;
                end
            end
            S_ABORT: begin
                if (r_pend) begin
                    if (w_fin) w_nxt = S_IDLE;
                end else begin
                    w_issue  = 1'b1;
                    w_iwr    = 1'b1;
                    w_iwdata = w_ctrl_abort;
                end
            end
            default: begin
                // An abort waits for the outstanding transaction to settle first.
                if (r_pend) begin
                    if (w_fin) begin
                        if (w_abt)      w_nxt = S_ABORT;
                        else if (w_bad) w_nxt = S_ERR;
                        else begin
                            case (r_state)
                                S_LOAD: begin
                                    w_lut_ok = 1'b1;
                                    if (r_tcnt == c_TW'(NTRIG - 1)) w_nxt = S_ARM;
                                end
                                S_ARM:  w_nxt = S_POLL;
                                S_POLL: begin
                                    if (bus.regrdata[2])       w_nxt = S_READ;
                                    else if (!bus.regrdata[3]) w_nxt = S_ERR;
                                    else                       w_retry = 1'b1;
                                end
                                default: w_rd_ack = 1'b1;
                            endcase
                        end
                    end
                end else if (w_abt) begin
                    w_nxt = S_ABORT;
                end else begin
                    case (r_state)
                        S_LOAD: begin
                            w_trig_rdy = 1'b1;
                            if (bus.trig_valid) begin
                                w_issue  = 1'b1;
                                w_iwr    = 1'b1;
                                w_iaddr  = 12'd12;
                                w_iwdata = bus.trig_data;
                            end
                        end
                        S_ARM: begin
                            w_issue  = 1'b1;
                            w_iwr    = 1'b1;
                            w_iwdata = w_ctrl_start;
                        end
                        S_POLL: begin
                            if (r_gap == '0) w_issue = 1'b1;
                        end
                        default: begin
                            if (r_ovalid) begin
                                if (bus.out_ready) begin
                                    w_hs = 1'b1;
                                    if (w_last) w_nxt = S_DONE;
                                end
                            end else begin
                                w_issue = 1'b1;
                                w_iaddr = 12'd8;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend   <= 1'b0;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= 12'd0;
            r_wdata  <= 32'd0;
            r_tmo    <= '0;
            r_gap    <= '0;
            r_cnt    <= '0;
            r_tcnt   <= '0;
            r_tpos   <= 16'd0;
            r_trans  <= 1'b0;
            r_abt    <= 1'b0;
            r_ovalid <= 1'b0;
            r_odata  <= 32'd0;
        end else begin
            r_req <= w_issue;
            if (w_issue) begin
                r_pend  <= 1'b1;
                r_tmo   <= '0;
                r_wr    <= w_iwr;
                r_addr  <= w_iaddr;
                r_wdata <= w_iwdata;
            end else if (w_fin) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_tmo <= r_tmo + 1'b1;
            end

            r_abt <= w_busy_st && w_abt && (w_nxt != S_ABORT);

            if (w_start) begin
                r_tpos  <= bus.tpos;
                r_trans <= bus.trans;
                r_tcnt  <= '0;
            end else if (w_lut_ok) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_start)                                           r_gap <= '0;
            else if (w_retry)                                      r_gap <= c_GW'(POLLGAP);
            else if (r_state == S_POLL && !r_pend && r_gap != '0) r_gap <= r_gap - 1'b1;

            // Counter holds on the final word so it never wraps inside a sequence.
            if (r_state != S_READ)     r_cnt <= '0;
            else if (w_hs && !w_last)  r_cnt <= r_cnt + 1'b1;

            if (w_nxt != S_READ) begin
                r_ovalid <= 1'b0;
            end else if (w_rd_ack) begin
                r_ovalid <= 1'b1;
                r_odata  <= bus.regrdata;
            end else if (w_hs) begin
                r_ovalid <= 1'b0;
            end
        end
    end

    assign bus.regreq     = r_req;
    assign bus.regwr      = r_wr;
    assign bus.regaddr    = r_addr;
    assign bus.regwdata   = r_wdata;
    assign bus.trig_ready = w_trig_rdy;
    assign bus.out_valid  = r_ovalid;
    assign bus.out_data   = r_odata;
    assign bus.out_last   = r_ovalid && w_last;
    assign bus.busy       = w_busy_st || (r_state == S_ABORT);
    assign bus.done       = (r_state == S_DONE);
    assign bus.err        = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_hjdebug_seq.sv
// ============================================================================
// Module : tb_hjdebug_seq
// Brief  : Directed bench for hjdebug_seq with a behavioural capture core.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hjdebug_seq;
    localparam int N = 40, SIZ = 4, NTRIG = 16, POLLGAP = 8, TIMEOUT = 100;
    localparam int NW = 8;

    typedef struct {
        bit          wr;
        bit [11:0]   addr;
        bit [31:0]   wdata;
    } txn_t;

    typedef struct {
        int          err_lut;
        int          avail_poll;
        bit          running;
        int          rdy;
        logic [15:0] tpos;
        bit          trans;
        bit          e_done;
        bit          e_err;
        int          e_lut;
        int          e_arm;
        int          e_polls;
        int          e_words;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hjdebug_seq_if bif();

    hjdebug_seq #(.N(N), .SIZ(SIZ), .NTRIG(NTRIG), .POLLGAP(POLLGAP), .TIMEOUT(TIMEOUT))
        u_dut (.clk(clk), .rst(rst), .bus(bif.master));

    int checks = 0, failures = 0;
    int cyc = 0;

    // configuration owned by the main sequence
    int cfg_err_lut = -1, cfg_avail = 1000000, cfg_rdb = 0, cfg_late_req = 0, rdy_mode = 0;
    bit cfg_running = 1'b1, cfg_noack_arm = 1'b0, feed_en = 1'b0;
    int lg_base = 0, rx_base = 0, tr_base = 0, pb = 0;

    // state owned by the core model / monitors
    txn_t        tlog[$];
    logic [31:0] rx_data[$];
    bit          rx_last[$];
    int          tr_hs = 0, m_lut = 0, m_polls = 0, m_rds = 0, m_late_cnt = 0, m_arm_cyc = 0;
    bit          m_wait = 1'b0;
    txn_t        m_txn;

    wire any_out = |{bif.trig_ready, bif.out_valid, bif.out_data, bif.out_last, bif.busy,
                     bif.done, bif.err, bif.regreq, bif.regwr, bif.regaddr, bif.regwdata};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (bif.out_valid && bif.out_ready) begin
            rx_data.push_back(bif.out_data);
            rx_last.push_back(bif.out_last);
        end
        if (bif.trig_valid && bif.trig_ready) tr_hs++;
    end

    initial begin
        bif.trig_valid = 1'b0;
        bif.trig_data  = 32'd0;
        bif.out_ready  = 1'b0;
        forever begin
            @(negedge clk);
            bif.trig_valid = feed_en && ((tr_hs - tr_base) < NTRIG);
            bif.trig_data  = 32'hA500_0000 + 32'(tr_hs - tr_base);
            case (rdy_mode)
                0:       bif.out_ready = 1'b1;
                1:       bif.out_ready = ~bif.out_ready;
                2:       bif.out_ready = (cyc % 3 == 0);
                default: bif.out_ready = 1'b0;
            endcase
        end
    end

    // Capture core: ack one cycle after the request is seen.
    initial begin
        bif.regack = 1'b0; bif.regerr = 1'b0; bif.regrdata = 32'd0;
        forever begin
            @(negedge clk);
            bif.regack = 1'b0; bif.regerr = 1'b0;
            if (rst) begin
                m_wait = 1'b0;
            end else begin
                if (cfg_late_req != m_late_cnt) begin
                    m_late_cnt++;
                    bif.regack = 1'b1;
                end
                if (m_wait) begin
                    m_wait = 1'b0;
                    bif.regack = 1'b1;
                    bif.regrdata = 32'd0;
                    if (m_txn.wr && m_txn.addr == 12'd12) begin
                        m_lut++;
                        if (m_lut == cfg_err_lut) bif.regerr = 1'b1;
                    end else if (!m_txn.wr && m_txn.addr == 12'd0) begin
                        m_polls++;
                        bif.regrdata = {28'd0, cfg_running, (m_polls >= cfg_avail), 2'b00};
                    end else if (!m_txn.wr && m_txn.addr == 12'd8) begin
                        bif.regrdata = 32'hD000_0000 + 32'(m_rds - cfg_rdb);
                        m_rds++;
                    end
                end
                if (bif.regreq) begin
                    m_txn = '{wr: bif.regwr, addr: bif.regaddr, wdata: bif.regwdata};
                    tlog.push_back(m_txn);
                    if (bif.regwr && bif.regaddr == 12'd0 && bif.regwdata[0]) m_arm_cyc = cyc;
                    m_wait = !(cfg_noack_arm && bif.regwr && bif.regaddr == 12'd0 && bif.regwdata[0]);
                end
            end
        end
    end

    task automatic prep(input vec_t v);
        cfg_err_lut = (v.err_lut == 0) ? -1 : m_lut + v.err_lut;
        cfg_avail   = m_polls + v.avail_poll;
        cfg_running = v.running;
        cfg_rdb     = m_rds;
        rdy_mode    = v.rdy;
    endtask

    task automatic start_seq(input logic [15:0] tp, input bit tr);
        lg_base = tlog.size();
        rx_base = rx_data.size();
        tr_base = tr_hs;
        pb      = m_polls;
        @(negedge clk);
        bif.tpos = tp; bif.trans = tr; bif.go = 1'b1;
        @(negedge clk);
        bif.go  = 1'b0;
        feed_en = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bif.busy && n < 4000) begin
            @(negedge clk);
            n++;
        end
        feed_en = 1'b0;
        chk(name, bif.busy, 0);
    endtask

    int nlut, narm, nabt;
    bit lutok, rxok;
    logic [31:0] armd;

    task automatic scan();
        nlut = 0; narm = 0; nabt = 0; lutok = 1'b1; armd = 32'd0; rxok = 1'b1;
        for (int i = lg_base; i < tlog.size(); i++) begin
            if (tlog[i].wr && tlog[i].addr == 12'd12) begin
                if (tlog[i].wdata !== 32'hA500_0000 + 32'(nlut)) lutok = 1'b0;
                nlut++;
            end else if (tlog[i].wr && tlog[i].addr == 12'd0) begin
                if (tlog[i].wdata[0]) begin narm++; armd = tlog[i].wdata; end
                if (tlog[i].wdata[1]) nabt++;
            end
        end
        for (int i = rx_base; i < rx_data.size(); i++) begin
            if (rx_data[i] !== 32'hD000_0000 + 32'(i - rx_base)) rxok = 1'b0;
            if (rx_last[i] !== (i - rx_base == NW - 1)) rxok = 1'b0;
        end
    endtask

    task automatic run_seq(input vec_t v, input int id);
        prep(v);
        start_seq(v.tpos, v.trans);
        wait_idle($sformatf("v%0d_end", id));
        scan();
        chk($sformatf("v%0d_done", id), bif.done, v.e_done);
        chk($sformatf("v%0d_err", id), bif.err, v.e_err);
        chk($sformatf("v%0d_nlut", id), nlut, v.e_lut);
        chk($sformatf("v%0d_lutdata", id), lutok, 1);
        chk($sformatf("v%0d_narm", id), narm, v.e_arm);
        if (narm > 0)
            chk($sformatf("v%0d_armword", id), armd, {v.tpos, 7'd0, v.trans, 6'd0, 2'b01});
        chk($sformatf("v%0d_polls", id), m_polls - pb, v.e_polls);
        chk($sformatf("v%0d_words", id), rx_data.size() - rx_base, v.e_words);
        chk($sformatf("v%0d_rxdata", id), rxok, 1);
    endtask

    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n;
        int lsz;
        rst = 1'b1; bif.go = 1'b0; bif.abort = 1'b0; bif.tpos = 16'd0; bif.trans = 1'b0;
        #1 chk("reset_outputs", any_out, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        //          errl avl run rdy tpos       tr  done err lut arm polls words
        vecs[0] = '{0,   3,  1,  0,  16'h1234,  0,  1,   0,  16, 1,  3,    8};
        vecs[1] = '{0,   1,  1,  1,  16'hBEEF,  1,  1,   0,  16, 1,  1,    8};
        vecs[2] = '{2,   1,  1,  0,  16'h0001,  0,  0,   1,  2,  0,  0,    0};
        vecs[3] = '{0,   99, 0,  0,  16'h00F0,  1,  0,   1,  16, 1,  1,    0};
        vecs[4] = '{0,   2,  1,  2,  16'hFFFF,  1,  1,   0,  16, 1,  2,    8};
        for (int i = 0; i < 5; i++) run_seq(vecs[i], i);

        // go together with abort while DONE: go must be ignored
        @(negedge clk);
        bif.go = 1'b1; bif.abort = 1'b1;
        @(negedge clk);
        bif.go = 1'b0; bif.abort = 1'b0;
        chk("goabort_busy", bif.busy, 0);
        chk("goabort_done", bif.done, 1);

        // abort during the poll gap
        prep('{0, 99, 1, 0, 16'h5A5A, 1, 0, 0, 0, 0, 0, 0});
        start_seq(16'h5A5A, 1'b1);
        n = 0;
        while (m_polls - pb < 1 && n < 2000) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        bif.abort = 1'b1;
        @(negedge clk);
        bif.abort = 1'b0;
        wait_idle("abort_end");
        scan();
        chk("abort_done", bif.done, 0);
        chk("abort_err", bif.err, 0);
        chk("abort_nabt", nabt, 1);
        chk("abort_word", {tlog[tlog.size()-1].wr, tlog[tlog.size()-1].addr, tlog[tlog.size()-1].wdata},
            {1'b1, 12'd0, 16'h5A5A, 7'd0, 1'b1, 6'd0, 2'b10});
        chk("abort_polls", m_polls - pb, 1);

        // ARM write never acknowledged
        prep('{0, 1, 1, 0, 16'h0042, 0, 0, 0, 0, 0, 0, 0});
        cfg_noack_arm = 1'b1;
        start_seq(16'h0042, 1'b0);
        n = 0;
        while (!bif.err && n < 2000) begin @(negedge clk); n++; end
        chk("tmo_cycles", cyc - m_arm_cyc, TIMEOUT);
        chk("tmo_busy", bif.busy, 0);
        lsz = tlog.size();
        cfg_late_req++;
        repeat (4) @(negedge clk);
        chk("late_ack_err", bif.err, 1);
        chk("late_ack_done", bif.done, 0);
        chk("late_ack_notxn", tlog.size(), lsz);
        cfg_noack_arm = 1'b0;
        feed_en = 1'b0;

        // reset while a readout word is waiting
        prep('{0, 1, 1, 3, 16'h7777, 0, 0, 0, 0, 0, 0, 0});
        start_seq(16'h7777, 1'b0);
        n = 0;
        while (!bif.out_valid && n < 2000) begin @(negedge clk); n++; end
        chk("rstread_valid", bif.out_valid, 1);
        #2 rst = 1'b1;
        #1 chk("rstread_outputs", any_out, 0);
        feed_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_seq(vecs[0], 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
